// File: rtl/mux_key_with_default_pkg.sv
// Shared helpers for the keyed multiplexer: table geometry derived from key/data widths.
package mux_key_with_default_pkg;

    function automatic int unsigned pair_len(input int unsigned key_len, input int unsigned data_len);
        return key_len + data_len;
    endfunction

endpackage

// File: rtl/mux_key_lookup.sv
// Combinational priority matcher: returns the data of the lowest-index entry whose key matches,
// or the supplied default when nothing matches.
module mux_key_lookup
    import mux_key_with_default_pkg::*;
#(
    parameter int unsigned NR_KEY   = 2,
    parameter int unsigned KEY_LEN  = 1,
    parameter int unsigned DATA_LEN = 1,
    localparam int unsigned PAIR_LEN = pair_len(KEY_LEN, DATA_LEN),
    localparam int unsigned LUT_LEN  = NR_KEY * PAIR_LEN
) (
    input  logic [KEY_LEN-1:0]  key,
    input  logic [DATA_LEN-1:0] default_out,
    input  logic [LUT_LEN-1:0]  lut,
    output logic [DATA_LEN-1:0] data_c,
    output logic                hit_c
);

    logic [KEY_LEN-1:0]  entry_key  [NR_KEY];
    logic [DATA_LEN-1:0] entry_data [NR_KEY];

    // Entry 0 sits in the most-significant pair; key above data within a pair.
    for (genvar g = 0; g < int'(NR_KEY); g++) begin : g_entry
        assign entry_key[g]  = lut[(int'(NR_KEY) - g) * int'(PAIR_LEN) - 1 -: KEY_LEN];
        assign entry_data[g] = lut[(int'(NR_KEY) - g) * int'(PAIR_LEN) - int'(KEY_LEN) - 1 -: DATA_LEN];
    end

    // Scan from the highest index down so the lowest matching index is applied last.
    always_comb begin
        data_c = default_out;
        hit_c  = 1'b0;
        for (int i = int'(NR_KEY) - 1; i >= 0; i--) begin
            if (entry_key[i] == key) begin
                data_c = entry_data[i];
                hit_c  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_key_with_default.sv
// Keyed multiplexer with default: combinational lookup plus a one-cycle registered result.
module mux_key_with_default
    import mux_key_with_default_pkg::*;
#(
    parameter int unsigned NR_KEY   = 2,
    parameter int unsigned KEY_LEN  = 1,
    parameter int unsigned DATA_LEN = 1,
    localparam int unsigned PAIR_LEN = pair_len(KEY_LEN, DATA_LEN),
    localparam int unsigned LUT_LEN  = NR_KEY * PAIR_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_LEN-1:0]  key,
    input  logic [DATA_LEN-1:0] default_out,
    input  logic [LUT_LEN-1:0]  lut,
    input  logic                in_valid,
    output logic [DATA_LEN-1:0] out,
    output logic                hit,
    output logic                out_valid,
    output logic [DATA_LEN-1:0] comb_out
);

    logic lookup_hit_c;

    mux_key_lookup #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN)
    ) u_lookup (
        .key         (key),
        .default_out (default_out),
        .lut         (lut),
        .data_c      (comb_out),
        .hit_c       (lookup_hit_c)
    );

    // Result registers; out/hit hold their last value on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            hit       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= comb_out;
                hit <= lookup_hit_c;
            end
        end
    end

endmodule

// File: tb/tb_mux_key_with_default.sv
// Scoreboard bench for mux_key_with_default: two table configurations, directed vectors.
module tb_mux_key_with_default;

    logic clk;
    logic rst;

    // Configuration A: 11 entries, 4-bit key, 1-bit data
    logic [3:0]  key_a;
    logic [0:0]  dflt_a;
    logic [54:0] lut_a;
    logic        valid_a;
    logic [0:0]  out_a;
    logic        hit_a;
    logic        ovalid_a;
    logic [0:0]  comb_a;

    // Configuration B: 3 entries, 2-bit key, 4-bit data
    logic [1:0]  key_b;
    logic [3:0]  dflt_b;
    logic [17:0] lut_b;
    logic        valid_b;
    logic [3:0]  out_b;
    logic        hit_b;
    logic        ovalid_b;
    logic [3:0]  comb_b;

    logic [1:0] q_a [$];
    logic [4:0] q_b [$];

    int n_checks = 0;
    int n_fail   = 0;

    mux_key_with_default #(.NR_KEY(11), .KEY_LEN(4), .DATA_LEN(1)) dut_a (
        .clk(clk), .rst(rst), .key(key_a), .default_out(dflt_a), .lut(lut_a),
        .in_valid(valid_a), .out(out_a), .hit(hit_a), .out_valid(ovalid_a), .comb_out(comb_a)
    );

    mux_key_with_default #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(4)) dut_b (
        .clk(clk), .rst(rst), .key(key_b), .default_out(dflt_b), .lut(lut_b),
        .in_valid(valid_b), .out(out_b), .hit(hit_b), .out_valid(ovalid_b), .comb_out(comb_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop one expectation per presented result.
    initial begin
        forever begin
            @(negedge clk);
            if (ovalid_a === 1'b1) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_valid", 32'(ovalid_a), 32'd0);
                end else begin
                    logic [1:0] e;
                    e = q_a.pop_front();
                    check("a_out", 32'(out_a), 32'(e[1]));
                    check("a_hit", 32'(hit_a), 32'(e[0]));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (ovalid_b === 1'b1) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_valid", 32'(ovalid_b), 32'd0);
                end else begin
                    logic [4:0] e;
                    e = q_b.pop_front();
                    check("b_out", 32'(out_b), 32'(e[4:1]));
                    check("b_hit", 32'(hit_b), 32'(e[0]));
                end
            end
        end
    end

    task automatic drive_a(input logic [3:0] k, input logic d, input logic eo, input logic eh);
        key_a   = k;
        dflt_a  = d;
        valid_a = 1'b1;
        #1;
        check("a_comb", 32'(comb_a), 32'(eo));
        q_a.push_back({eo, eh});
    endtask

    task automatic issue_a(input logic [3:0] k, input logic d, input logic eo, input logic eh);
        @(posedge clk);
        #1;
        drive_a(k, d, eo, eh);
    endtask

    task automatic issue_b(input logic [1:0] k, input logic [3:0] d, input logic [3:0] eo, input logic eh);
        @(posedge clk);
        #1;
        key_b   = k;
        dflt_b  = d;
        valid_b = 1'b1;
        #1;
        check("b_comb", 32'(comb_b), 32'(eo));
        q_b.push_back({eo, eh});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out"},   32'(out_a),    32'd0);
        check({tag, "_hit"},   32'(hit_a),    32'd0);
        check({tag, "_valid"}, 32'(ovalid_a), 32'd0);
    endtask

    initial begin
        rst     = 1'b0;
        key_a   = 4'b0001;
        dflt_a  = 1'b0;
        valid_a = 1'b0;
        key_b   = 2'b00;
        dflt_b  = 4'h0;
        valid_b = 1'b0;
        lut_a = {4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0010, 1'b0, 4'b1010, 1'b1,
                 4'b0011, 1'b1, 4'b1011, 1'b1, 4'b1110, 1'b1, 4'b1111, 1'b1,
                 4'b0101, 1'b0, 4'b1101, 1'b0, 4'b0100, 1'b0};
        lut_b = {2'b01, 4'hA, 2'b01, 4'h5, 2'b10, 4'h3};

        // Reset asserted before any clock edge must clear outputs at once
        #2 rst = 1'b1;
        #1;
        check_cleared("reset_a");
        check("reset_b_valid", 32'(ovalid_b), 32'd0);
        check("reset_b_out", 32'(out_b), 32'd0);
        check("reset_comb_a", 32'(comb_a), 32'd1);
        #9 rst = 1'b0;

        // Scenario 1 and 2, including first and last table entries
        issue_a(4'b0001, 1'b0, 1'b1, 1'b1);
        issue_a(4'b0110, 1'b1, 1'b1, 1'b0);
        issue_a(4'b0110, 1'b0, 1'b0, 1'b0);
        issue_a(4'b0000, 1'b1, 1'b0, 1'b1);
        issue_a(4'b0100, 1'b1, 1'b0, 1'b1);
        issue_a(4'b1010, 1'b0, 1'b1, 1'b1);
        idle();

        // Scenario 4: sparse valid pulses, hold on the gap cycle
        issue_a(4'b1111, 1'b0, 1'b1, 1'b1);
        idle();
        @(posedge clk);
        #1;
        check("gap_valid", 32'(ovalid_a), 32'd0);
        check("gap_out_hold", 32'(out_a), 32'd1);
        check("gap_hit_hold", 32'(hit_a), 32'd1);
        drive_a(4'b0101, 1'b0, 1'b0, 1'b1);
        idle();
        idle();

        // Scenario 3: duplicate keys resolve to the lowest index
        issue_b(2'b01, 4'hC, 4'hA, 1'b1);
        issue_b(2'b10, 4'hC, 4'h3, 1'b1);
        issue_b(2'b00, 4'hC, 4'hC, 1'b0);
        issue_b(2'b11, 4'h6, 4'h6, 1'b0);
        idle();
        idle();

        // Scenario 5: asynchronous reset mid-cycle while out=1
        issue_a(4'b0001, 1'b0, 1'b1, 1'b1);
        idle();
        idle();
        check("pre_reset_out", 32'(out_a), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_cleared("async_reset");
        key_a = 4'b1111;
        #1 check("rst_comb_hit", 32'(comb_a), 32'd1);
        key_a  = 4'b0110;
        dflt_a = 1'b1;
        #1 check("rst_comb_dflt1", 32'(comb_a), 32'd1);
        dflt_a = 1'b0;
        #1 check("rst_comb_dflt0", 32'(comb_a), 32'd0);
        key_a   = 4'b0001;
        valid_a = 1'b1;
        @(posedge clk);
        #1;
        check_cleared("rst_ignores_valid");
        valid_a = 1'b0;
        #2 rst = 1'b0;

        // A sampled result is dropped when reset follows the sampling edge
        issue_a(4'b0001, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        valid_a = 1'b0;
        q_a.delete();
        #1;
        check_cleared("drop_after_sample");
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check_cleared("post_drop_idle");

        // Normal operation resumes after reset release
        issue_a(4'b1111, 1'b0, 1'b1, 1'b1);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("a_drain", 32'(q_a.size()), 32'd0);
        check("b_drain", 32'(q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
